// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared widths, signed datapath types and 8-bit saturation helper
// Revision : 1.0
// ============================================================================
package conv_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int ACC_WIDTH    = 32;
    localparam int KERNEL_ELEMS = 9;

    typedef logic signed [DATA_WIDTH-1:0]   pixel_t;
    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;

    function automatic pixel_t sat8(input acc_t a);
        if (a > acc_t'(127)) begin
            return pixel_t'(127);
        end
        if (a < acc_t'(-128)) begin
            return pixel_t'(-128);
        end
        return a[DATA_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
// requant_sat : round-half-up arithmetic right shift, saturate to 8 bits.
//               CONV_RELU_EN additionally clamps negative results to zero.
// Revision    : 1.0
// ============================================================================
module requant_sat
    import conv_pkg::*;
#(
    parameter int SHIFT_WIDTH = 5
) (
    input  acc_t                   acc_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    output pixel_t                 pix_o
);

    // One guard bit keeps the rounding add from wrapping before the shift.
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] shr;
    pixel_t                    sat;

    always_comb begin
        ext  = {acc_i[ACC_WIDTH-1], acc_i};
        half = '0;
        rnd  = ext;
        shr  = ext;
        if (shift_i != '0) begin
            half = (ACC_WIDTH+1)'(1) <<< (shift_i - 1'b1);
            rnd  = ext + half;
            shr  = rnd >>> shift_i;
        end
        sat   = sat8(shr[ACC_WIDTH-1:0]);
        pix_o = sat;
`ifdef CONV_RELU_EN
        if (sat < 0) begin
            pix_o = '0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_mac.sv
`default_nettype none
// ============================================================================
// conv3x3_mac : 4-stage 3x3/1x1 convolution MAC with bias, requantization and
//               FIFO backpressure stall. Optional ReLU via CONV_RELU_EN.
// Revision    : 1.0
// ============================================================================
module conv3x3_mac #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAXIMUM_SIZE = 9,
    parameter int ACC_WIDTH    = 32,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [MAXIMUM_SIZE*DATA_WIDTH-1:0] window,
    input  logic                               window_valid,
    output logic                               window_ready,
    input  logic [1:0]                         window_dim,
    input  logic                               weight_wr_en,
    input  logic [3:0]                         weight_addr,
    input  logic [DATA_WIDTH-1:0]              weight_data,
    input  logic [ACC_WIDTH-1:0]               bias,
    input  logic [SHIFT_WIDTH-1:0]             shift,
    input  logic                               out_full,
    output logic                               out_wr_en,
    output logic [DATA_WIDTH-1:0]              out_data
);
    import conv_pkg::*;

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int PSUM_W = PROD_W + 2;
    localparam int GROUPS = MAXIMUM_SIZE / 3;

    logic                         stall;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] weight_q [MAXIMUM_SIZE];
    logic signed [PROD_W-1:0]     prod_d   [MAXIMUM_SIZE];
    logic signed [PROD_W-1:0]     prod_q   [MAXIMUM_SIZE];
    logic signed [PSUM_W-1:0]     psum_d   [GROUPS];
    logic signed [PSUM_W-1:0]     psum_q   [GROUPS];
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         s1_valid_q;
    logic                         s2_valid_q;
    logic                         s3_valid_q;
    logic                         s4_valid_q;
    logic [DATA_WIDTH-1:0]        out_data_q;
    pixel_t                       requant_pix;

    assign stall        = s4_valid_q & out_full;
    assign window_ready = window_valid & ~stall & reset_n;
    assign accept       = window_ready;
    assign out_wr_en    = s4_valid_q & ~out_full;
    assign out_data     = out_data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < MAXIMUM_SIZE; k++) begin
                weight_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAXIMUM_SIZE; k++) begin
                if (weight_wr_en && (weight_addr == 4'(k))) begin
                    weight_q[k] <= weight_data;
                end
            end
        end
    end

    // In 1x1 mode only the centre-less element 0 contributes.
    generate
        for (genvar k = 0; k < MAXIMUM_SIZE; k++) begin : g_prod
            logic signed [PROD_W-1:0] mul;
            assign mul = $signed(window[k*DATA_WIDTH +: DATA_WIDTH]) * weight_q[k];
            if (k == 0) begin : g_keep
                assign prod_d[k] = mul;
            end else begin : g_mask
                assign prod_d[k] = (window_dim == 2'd1) ? '0 : mul;
            end
        end

        for (genvar g = 0; g < GROUPS; g++) begin : g_psum
            assign psum_d[g] = PSUM_W'(prod_q[3*g])
                             + PSUM_W'(prod_q[3*g+1])
                             + PSUM_W'(prod_q[3*g+2]);
        end
    endgenerate

    always_comb begin
        acc_d = $signed(bias);
        for (int g = 0; g < GROUPS; g++) begin
            acc_d = acc_d + ACC_WIDTH'(psum_q[g]);
        end
    end

    requant_sat #(
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc_i   (acc_q),
        .shift_i (shift),
        .pix_o   (requant_pix)
    );

    // Global stall: every stage freezes together, so no bubbles collapse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s4_valid_q <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            for (int k = 0; k < MAXIMUM_SIZE; k++) begin
                prod_q[k] <= '0;
            end
            for (int g = 0; g < GROUPS; g++) begin
                psum_q[g] <= '0;
            end
        end else if (!stall) begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s4_valid_q <= s3_valid_q;
            if (accept) begin
                for (int k = 0; k < MAXIMUM_SIZE; k++) begin
                    prod_q[k] <= prod_d[k];
                end
            end
            if (s1_valid_q) begin
                for (int g = 0; g < GROUPS; g++) begin
                    psum_q[g] <= psum_d[g];
                end
            end
            if (s2_valid_q) begin
                acc_q <= acc_d;
            end
            if (s3_valid_q) begin
                out_data_q <= requant_pix;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_mac.sv
`default_nettype none
// ============================================================================
// tb_conv3x3_mac : scenario tasks plus a queue-based reference model of the
//                  convolution pipeline (results, latency, stall behaviour).
// Revision       : 1.0
// ============================================================================
module tb_conv3x3_mac;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [71:0] window;
    logic        window_valid;
    logic        window_ready;
    logic [1:0]  window_dim;
    logic        weight_wr_en;
    logic [3:0]  weight_addr;
    logic [7:0]  weight_data;
    logic [31:0] bias;
    logic [4:0]  shift;
    logic        out_full;
    logic        out_wr_en;
    logic [7:0]  out_data;

    conv3x3_mac #(
        .DATA_WIDTH   (8),
        .MAXIMUM_SIZE (9),
        .ACC_WIDTH    (32),
        .SHIFT_WIDTH  (5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .window       (window),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .window_dim   (window_dim),
        .weight_wr_en (weight_wr_en),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .bias         (bias),
        .shift        (shift),
        .out_full     (out_full),
        .out_wr_en    (out_wr_en),
        .out_data     (out_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        int               age;
        logic signed [7:0] val;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    int   n_wr  = 0;
    int   wm [9];
    ent_t q [$];
    logic s4m;
    logic stall_m;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference result from the arithmetic rules: dot product, bias, wrap, round, saturate.
    function automatic logic signed [7:0] ref_pixel(input logic [71:0] win, input logic [1:0] dim,
                                                    input int bias_v, input int sh);
        longint s;
        longint r;
        int     acc;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            if (!(dim == 2'd1 && k != 0)) begin
                s += longint'($signed(win[k*8 +: 8])) * longint'(wm[k]);
            end
        end
        acc = int'(s + longint'(bias_v));
        if (sh > 0) r = (longint'(acc) + (longint'(1) << (sh - 1))) >>> sh;
        else        r = longint'(acc);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`ifdef CONV_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[7:0];
    endfunction

    // Each queued window ages one step per unstalled edge and sits in the output stage at age 4.
    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            for (int k = 0; k < 9; k++) wm[k] = 0;
            total++;
            if (out_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL rst_wr_en: got %b want 0", out_wr_en);
            end
        end else begin
            s4m     = (q.size() > 0) && (q[0].age == 4);
            stall_m = s4m && out_full;
            total++;
            if (window_ready !== (window_valid & ~stall_m)) begin
                bad++;
                $display("FAIL window_ready @%0d: got %b want %b", cyc, window_ready, window_valid & ~stall_m);
            end
            total++;
            if (out_wr_en !== (s4m & ~out_full)) begin
                bad++;
                $display("FAIL out_wr_en @%0d: got %b want %b", cyc, out_wr_en, s4m & ~out_full);
            end
            if (out_wr_en === 1'b1) begin
                n_wr++;
                if (s4m) begin
                    total++;
                    if ($signed(out_data) !== q[0].val) begin
                        bad++;
                        $display("FAIL out_data @%0d: got %0d want %0d", cyc, $signed(out_data), q[0].val);
                    end
                end
            end
            if (!stall_m) begin
                if (s4m) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (window_ready === 1'b1) begin
                    q.push_back('{age: 1, val: ref_pixel(window, window_dim, $signed(bias), int'(shift))});
                end
            end
            if (weight_wr_en && weight_addr < 4'd9) wm[weight_addr] = int'($signed(weight_data));
        end
    end

    function automatic logic [71:0] pack(input int v [9]);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v[k]);
        return w;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic set_weights(input int v [9]);
        for (int k = 0; k < 9; k++) begin
            weight_wr_en = 1'b1;
            weight_addr  = 4'(k);
            weight_data  = 8'(v[k]);
            @(posedge clock); #1;
        end
        weight_wr_en = 1'b0;
    endtask

    task automatic push(input logic [71:0] w, input logic [1:0] d);
        bit got = 0;
        window       = w;
        window_dim   = d;
        window_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clock);
            if (window_ready === 1'b1) begin
                got     = 1;
                acc_cyc = cyc;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL push_timeout: got no accept want accept within 200 cycles");
        end
        @(posedge clock); #1;
        window_valid = 1'b0;
    endtask

    task automatic wait_out(output logic signed [7:0] v, output int lat);
        bit got = 0;
        v   = 'x;
        lat = -1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock);
            if (out_wr_en === 1'b1) begin
                got = 1;
                v   = $signed(out_data);
                lat = cyc - acc_cyc;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clock);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        window_valid = 1'b1;
        window       = rand_win();
        repeat (2) @(negedge clock);
        total++;
        if (window_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0", window_ready);
        end
        total++;
        if (out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_out_data: got %0d want 0", out_data);
        end
        @(posedge clock); #1;
        window_valid = 1'b0;
        reset_n      = 1'b1;
    endtask

    task automatic test_identity();
        int w [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        int x [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        logic signed [7:0] v;
        int lat;
        bias  = 0;
        shift = 0;
        set_weights(w);
        push(pack(x), 2'd3);
        wait_out(v, lat);
        total++;
        if (v !== 8'sd5) begin
            bad++;
            $display("FAIL identity_val: got %0d want 5", v);
        end
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL identity_latency: got %0d want 4", lat);
        end
        wait_drain();
    endtask

    task automatic test_full_kernel();
        int w [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        int x [9] = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
        logic signed [7:0] v;
        int lat;
        bias  = -32'sd10;
        shift = 5'd2;
        set_weights(w);
        push(pack(x), 2'd3);
        wait_out(v, lat);
        total++;
        if (v !== 8'sd20) begin
            bad++;
            $display("FAIL full_kernel: got %0d want 20", v);
        end
        wait_drain();
    endtask

    task automatic test_saturation();
        int wp [9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        int wn [9] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        int x  [9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        logic signed [7:0] v;
        logic signed [7:0] want_neg;
        int lat;
`ifdef CONV_RELU_EN
        want_neg = 8'sd0;
`else
        want_neg = -8'sd128;
`endif
        bias  = 0;
        shift = 0;
        set_weights(wp);
        push(pack(x), 2'd3);
        wait_out(v, lat);
        total++;
        if (v !== 8'sd127) begin
            bad++;
            $display("FAIL sat_pos: got %0d want 127", v);
        end
        set_weights(wn);
        push(pack(x), 2'd3);
        wait_out(v, lat);
        total++;
        if (v !== want_neg) begin
            bad++;
            $display("FAIL sat_neg: got %0d want %0d", v, want_neg);
        end
        wait_drain();
    endtask

    task automatic test_1x1();
        int w [9] = '{3, 5, 5, 5, 5, 5, 5, 5, 5};
        int x [9] = '{-4, 100, 100, 100, 100, 100, 100, 100, 100};
        logic signed [7:0] v;
        logic signed [7:0] want;
        int lat;
`ifdef CONV_RELU_EN
        want = 8'sd0;
`else
        want = -8'sd12;
`endif
        bias  = 0;
        shift = 0;
        set_weights(w);
        push(pack(x), 2'd1);
        wait_out(v, lat);
        total++;
        if (v !== want) begin
            bad++;
            $display("FAIL one_by_one: got %0d want %0d", v, want);
        end
        wait_drain();
    endtask

    // Back-to-back stream with weight writes landing on accept edges (old weight applies).
    task automatic test_back_to_back();
        int n0;
        for (int cfg = 0; cfg < 2; cfg++) begin
            n0 = n_wr;
            if (cfg == 0) begin
                bias  = 32'($urandom_range(0, 4000)) - 32'd2000;
                shift = 5'($urandom_range(0, 8));
            end else begin
                bias  = $urandom();
                shift = 5'($urandom_range(0, 31));
            end
            for (int i = 0; i < 30; i++) begin
                weight_wr_en = ($urandom_range(0, 1) == 1);
                weight_addr  = 4'($urandom_range(0, 15));
                weight_data  = 8'($urandom_range(0, 255));
                push(rand_win(), 2'($urandom_range(0, 3)));
                weight_wr_en = 1'b0;
            end
            wait_drain();
            total++;
            if (n_wr - n0 !== 30) begin
                bad++;
                $display("FAIL b2b_count cfg%0d: got %0d want 30", cfg, n_wr - n0);
            end
        end
    endtask

    task automatic test_backpressure();
        int  n0 = n_wr;
        bit  done = 0;
        bias  = 32'($urandom_range(0, 200)) - 32'd100;
        shift = 5'd3;
        fork
            begin
                for (int i = 0; i < 20; i++) push(rand_win(), 2'd3);
                done = 1;
            end
            begin
                int c = 0;
                while (!done) begin
                    @(posedge clock); #1;
                    c++;
                    if (c % 2 == 0) out_full = ~out_full;
                end
            end
        join
        out_full = 1'b0;
        wait_drain();
        total++;
        if (n_wr - n0 !== 20) begin
            bad++;
            $display("FAIL bp_count: got %0d want 20", n_wr - n0);
        end
    endtask

    task automatic test_reset_mid();
        int w [9] = '{7, -3, 2, 9, 1, -6, 4, 5, -2};
        int n0;
        logic signed [7:0] v;
        int lat;
        bias  = 0;
        shift = 0;
        set_weights(w);
        for (int i = 0; i < 3; i++) push(rand_win(), 2'd3);
        window_valid = 1'b1;
        reset_n      = 1'b0;
        #1;
        total++;
        if (out_wr_en !== 1'b0 || window_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got wr_en=%b ready=%b want 0 0", out_wr_en, window_ready);
        end
        n0 = n_wr;
        @(posedge clock); @(posedge clock); #1;
        window_valid = 1'b0;
        reset_n      = 1'b1;
        repeat (10) @(negedge clock);
        total++;
        if (n_wr !== n0) begin
            bad++;
            $display("FAIL stale_out: got %0d writes want 0", n_wr - n0);
        end
        @(posedge clock); #1;
        push(rand_win(), 2'd3);
        wait_out(v, lat);
        total++;
        if (v !== 8'sd0) begin
            bad++;
            $display("FAIL cleared_weights: got %0d want 0", v);
        end
        wait_drain();
    endtask

    initial begin
        reset_n      = 1'b0;
        window       = '0;
        window_valid = 1'b0;
        window_dim   = 2'd3;
        weight_wr_en = 1'b0;
        weight_addr  = '0;
        weight_data  = '0;
        bias         = '0;
        shift        = '0;
        out_full     = 1'b0;
        test_reset();
        test_identity();
        test_full_kernel();
        test_saturation();
        test_1x1();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
